// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter and related round-robin pickers.
package dm_arb_pkg;

   localparam int unsigned DEF_CORES  = 4;
   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned STAT_W     = 16;
   localparam int unsigned MAX_CORES  = 8;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } pick_t;

   // First set bit of req scanning ptr+1, ptr+2, ... modulo cores.
   function automatic pick_t rr_pick(input logic [MAX_CORES-1:0] req,
                                     input logic [2:0]           ptr,
                                     input int unsigned          cores);
      pick_t       res;
      int unsigned cand;
      res = '0;
      for (int unsigned k = 1; k <= MAX_CORES; k++) begin
         if (k <= cores) begin
            cand = (32'(ptr) + k) % cores;
            if (!res.valid && req[cand[2:0]]) begin
               res.valid = 1'b1;
               res.idx   = cand[2:0];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dm_arbiter_rr.sv
// rr_arbiter: CORES-wide round-robin picker with its own priority pointer.
module rr_arbiter
   import dm_arb_pkg::*;
#(
   parameter int unsigned CORES = DEF_CORES,
   parameter int unsigned IDX_W = (CORES > 1) ? $clog2(CORES) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CORES-1:0] req,
   output logic             grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0]     ptr;
   logic [MAX_CORES-1:0] req_pad;
   pick_t                pick;

   // Pad the request vector to the package width and pick the winner.
   always_comb begin
      req_pad            = '0;
      req_pad[CORES-1:0] = req;
      pick               = rr_pick(req_pad, 3'(ptr), CORES);
   end

   assign grant     = pick.valid;
   assign grant_idx = IDX_W'(pick.idx);

   // Pointer follows the last winner; reset leaves core 0 with top priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= IDX_W'(CORES - 1);
      end else if (pick.valid) begin
         ptr <= grant_idx;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter between N cores and a single-port data memory.
// Optional macro DM_ARB_STATS_EN adds per-core grant counters and a stall counter.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int unsigned CORES  = DEF_CORES,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CORES-1:0]         core_req,
   input  logic [CORES-1:0]         core_we,
   input  logic [CORES*ADDR_W-1:0]  core_addr,
   input  logic [CORES*DATA_W-1:0]  core_wdata,
   output logic [CORES-1:0]         core_ack,
   output logic [DATA_W-1:0]        core_rdata,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata
`ifdef DM_ARB_STATS_EN
   ,
   output logic [CORES*STAT_W-1:0]  stat_grants,
   output logic [STAT_W-1:0]        stat_stall
`endif
);

   localparam int unsigned IDX_W = (CORES > 1) ? $clog2(CORES) : 1;

   logic             inflight_v;
   logic [IDX_W-1:0] inflight_idx;
   logic [CORES-1:0] inflight_mask;
   logic [CORES-1:0] eligible;
   logic             grant;
   logic [IDX_W-1:0] grant_idx;
   logic             issue;

   // The core being acked this cycle is masked so it cannot be granted twice.
   always_comb begin
      inflight_mask = '0;
      if (inflight_v) begin
         inflight_mask[inflight_idx] = 1'b1;
      end
      eligible = core_req & ~inflight_mask;
   end

   rr_arbiter #(
      .CORES (CORES),
      .IDX_W (IDX_W)
   ) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (eligible),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign issue = grant & rst_n;

   // Drive the memory port from the winning core; idle port is all zeros.
   always_comb begin
      mem_en    = issue;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (issue) begin
         mem_we    = core_we[grant_idx];
         mem_addr  = core_addr[grant_idx*ADDR_W +: ADDR_W];
         mem_wdata = core_wdata[grant_idx*DATA_W +: DATA_W];
      end
   end

   // Remember the granted core so it is acked in the following cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight_v   <= 1'b0;
         inflight_idx <= '0;
      end else begin
         inflight_v   <= grant;
         inflight_idx <= grant_idx;
      end
   end

   assign core_ack   = inflight_mask;
   assign core_rdata = mem_rdata;

`ifdef DM_ARB_STATS_EN
   logic [CORES-1:0] grant_mask;

   // One-hot view of this cycle's grant for the statistics counters.
   always_comb begin
      grant_mask = '0;
      if (issue) begin
         grant_mask[grant_idx] = 1'b1;
      end
   end

   // Saturating grant counters per core and a stall counter for lost/masked requests.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_grants <= '0;
         stat_stall  <= '0;
      end else begin
         for (int unsigned i = 0; i < CORES; i++) begin
            if (grant_mask[i] && (stat_grants[i*STAT_W +: STAT_W] != '1)) begin
               stat_grants[i*STAT_W +: STAT_W] <= stat_grants[i*STAT_W +: STAT_W] + STAT_W'(1);
            end
         end
         if ((|(core_req & ~grant_mask)) && (stat_stall != '1)) begin
            stat_stall <= stat_stall + STAT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed vector table, hand sequences,
// and randomized cores checked against a behavioural reference model.
module tb_dm_arbiter;

   localparam int NC = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    core_req, core_we, core_ack;
   logic [127:0]  core_addr, core_wdata;
   logic [31:0]   core_rdata, mem_addr, mem_wdata, mem_rdata;
   logic          mem_en, mem_we;
`ifdef DM_ARB_STATS_EN
   logic [63:0]   stat_grants;
   logic [15:0]   stat_stall;
`endif

   dm_arbiter #(.CORES(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_ack   (core_ack),
      .core_rdata (core_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
`ifdef DM_ARB_STATS_EN
      ,
      .stat_grants(stat_grants),
      .stat_stall (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   // Single-port memory: 16 words, word i initialised to i+1, read data one cycle later.
   logic [31:0] mem [16];
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         if (mem_en) begin
            if (mem_we) mem[mem_addr[3:0]] = mem_wdata;
            else        mem_rdata <= mem[mem_addr[3:0]];
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Stimulus state
   logic        s_rst;
   logic [3:0]  s_req, s_we;
   logic [31:0] s_addr  [NC];
   logic [31:0] s_wdata [NC];

   // Reference model state
   int          m_ptr = NC - 1;
   int          m_infl = -1;
   int          m_win;
   logic        m_load = 1'b0;
   logic [31:0] m_rdata = '0;
   logic [31:0] ref_mem [16];
   int          m_gcnt [NC];
   int          m_stall = 0;

   task automatic cycle_begin();
      logic [3:0] exp_ack;
      rst_n    = s_rst;
      core_req = s_req;
      core_we  = s_we;
      for (int i = 0; i < NC; i++) begin
         core_addr[i*32 +: 32]  = s_addr[i];
         core_wdata[i*32 +: 32] = s_wdata[i];
      end
      #3;
      exp_ack = '0;
      if (m_infl >= 0) exp_ack[m_infl] = 1'b1;
      check("core_ack", 32'(core_ack), 32'(exp_ack));
      if (m_infl >= 0 && m_load) check("core_rdata", core_rdata, m_rdata);
      m_win = -1;
      if (s_rst) begin
         for (int k = 1; k <= NC; k++) begin
            int c;
            c = (m_ptr + k) % NC;
            if (m_win < 0 && s_req[c] && c != m_infl) m_win = c;
         end
      end
      check("mem_en", 32'(mem_en), 32'(m_win >= 0));
      if (m_win >= 0) begin
         check("mem_we",    32'(mem_we), 32'(s_we[m_win]));
         check("mem_addr",  mem_addr,  s_addr[m_win]);
         check("mem_wdata", mem_wdata, s_wdata[m_win]);
      end else begin
         check("mem_we idle",    32'(mem_we), 32'd0);
         check("mem_addr idle",  mem_addr,  32'd0);
         check("mem_wdata idle", mem_wdata, 32'd0);
      end
`ifdef DM_ARB_STATS_EN
      for (int i = 0; i < NC; i++)
         check($sformatf("stat_grants[%0d]", i), 32'(stat_grants[i*16 +: 16]), 32'(m_gcnt[i]));
      check("stat_stall", 32'(stat_stall), 32'(m_stall));
`endif
   endtask

   task automatic cycle_end();
      if (!s_rst) begin
         m_ptr   = NC - 1;
         m_infl  = -1;
         m_load  = 1'b0;
         m_stall = 0;
         for (int i = 0; i < NC; i++) m_gcnt[i] = 0;
      end else begin
         if (m_win >= 0) begin
            if (m_gcnt[m_win] < 65535) m_gcnt[m_win]++;
            m_ptr  = m_win;
            m_load = !s_we[m_win];
            if (s_we[m_win]) ref_mem[s_addr[m_win][3:0]] = s_wdata[m_win];
            else             m_rdata = ref_mem[s_addr[m_win][3:0]];
         end
         begin
            bit stalled;
            stalled = 1'b0;
            for (int i = 0; i < NC; i++) if (s_req[i] && i != m_win) stalled = 1'b1;
            if (stalled && m_stall < 65535) m_stall++;
         end
         m_infl = m_win;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic new_req(input int i);
      s_req[i]   = 1'b1;
      s_we[i]    = 1'($urandom_range(0, 1));
      s_addr[i]  = 32'($urandom_range(0, 15));
      s_wdata[i] = $urandom;
   endtask

   typedef struct packed {
      logic        rst;
      logic [3:0]  req;
      logic        en;
      logic [1:0]  win;
      logic [3:0]  ack;
      logic [31:0] rdata;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl [NV];

   initial begin
      int prev_acked;
      // Core i loads address i+3, which holds i+4.
      tbl[0]  = '{1'b0, 4'hF, 1'b0, 2'd0, 4'h0, 32'd0};
      tbl[1]  = '{1'b0, 4'hF, 1'b0, 2'd0, 4'h0, 32'd0};
      tbl[2]  = '{1'b0, 4'hF, 1'b0, 2'd0, 4'h0, 32'd0};
      tbl[3]  = '{1'b1, 4'hF, 1'b1, 2'd0, 4'h0, 32'd0};
      tbl[4]  = '{1'b1, 4'hF, 1'b1, 2'd1, 4'h1, 32'd4};
      tbl[5]  = '{1'b1, 4'hF, 1'b1, 2'd2, 4'h2, 32'd5};
      tbl[6]  = '{1'b1, 4'hF, 1'b1, 2'd3, 4'h4, 32'd6};
      tbl[7]  = '{1'b1, 4'hF, 1'b1, 2'd0, 4'h8, 32'd7};
      tbl[8]  = '{1'b1, 4'hF, 1'b1, 2'd1, 4'h1, 32'd4};
      tbl[9]  = '{1'b1, 4'h0, 1'b0, 2'd0, 4'h2, 32'd5};
      tbl[10] = '{1'b1, 4'h0, 1'b0, 2'd0, 4'h0, 32'd0};
      tbl[11] = '{1'b1, 4'h4, 1'b1, 2'd2, 4'h0, 32'd0};
      tbl[12] = '{1'b1, 4'h4, 1'b0, 2'd0, 4'h4, 32'd6};
      tbl[13] = '{1'b1, 4'h0, 1'b0, 2'd0, 4'h0, 32'd0};
      tbl[14] = '{1'b1, 4'h1, 1'b1, 2'd0, 4'h0, 32'd0};
      tbl[15] = '{1'b0, 4'h1, 1'b0, 2'd0, 4'h1, 32'd4};
      tbl[16] = '{1'b1, 4'hF, 1'b1, 2'd0, 4'h0, 32'd0};
      tbl[17] = '{1'b1, 4'h0, 1'b0, 2'd0, 4'h1, 32'd4};

      for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i + 1);
      for (int i = 0; i < NC; i++) m_gcnt[i] = 0;

      rst_n = 1'b0; core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
      @(posedge clk);
      #1;

      // Directed vector table
      for (int r = 0; r < NV; r++) begin
         s_rst = tbl[r].rst;
         s_req = tbl[r].req;
         s_we  = '0;
         for (int i = 0; i < NC; i++) begin
            s_addr[i]  = 32'(i + 3);
            s_wdata[i] = 32'(100 + i);
         end
         cycle_begin();
         check($sformatf("tbl%0d ack", r), 32'(core_ack), 32'(tbl[r].ack));
         check($sformatf("tbl%0d en", r), 32'(mem_en), 32'(tbl[r].en));
         if (tbl[r].en) check($sformatf("tbl%0d addr", r), mem_addr, 32'(tbl[r].win) + 32'd3);
         if (tbl[r].ack != 4'h0) check($sformatf("tbl%0d rdata", r), core_rdata, tbl[r].rdata);
         cycle_end();
      end

      // Store by core 1 then load by core 3 to the same address
      s_rst = 1'b0; s_req = '0; cycle_begin(); cycle_end();
      s_rst = 1'b1; s_req = 4'b1010; s_we = 4'b0010;
      s_addr[1] = 32'd0; s_wdata[1] = 32'd8; s_addr[3] = 32'd0; s_wdata[3] = 32'h55;
      cycle_begin();
      check("ord store we",    32'(mem_we), 32'd1);
      check("ord store addr",  mem_addr, 32'd0);
      check("ord store wdata", mem_wdata, 32'd8);
      cycle_end();
      cycle_begin();
      check("ord load en",  32'(mem_en), 32'd1);
      check("ord load we",  32'(mem_we), 32'd0);
      check("ord store ack", 32'(core_ack), 32'b0010);
      cycle_end();
      s_req = 4'b1000;
      cycle_begin();
      check("ord load ack",   32'(core_ack), 32'b1000);
      check("ord load rdata", core_rdata, 32'd8);
      cycle_end();
      s_req = '0; cycle_begin(); cycle_end();

`ifdef DM_ARB_STATS_EN
      // Eight cycles of full contention after reset
      s_rst = 1'b0; s_req = '0; s_we = '0; cycle_begin(); cycle_end();
      s_rst = 1'b1; s_req = 4'hF;
      for (int i = 0; i < NC; i++) s_addr[i] = 32'(i + 3);
      for (int c = 0; c < 8; c++) begin cycle_begin(); cycle_end(); end
      s_req = '0;
      cycle_begin();
      for (int i = 0; i < NC; i++)
         check($sformatf("stats grants core%0d", i), 32'(stat_grants[i*16 +: 16]), 32'd2);
      check("stats stall", 32'(stat_stall), 32'd8);
      cycle_end();
`endif

      // Randomized cores against the reference model
      s_req = '0;
      prev_acked = -1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (prev_acked >= 0) begin
            s_req[prev_acked] = 1'b0;
            if ($urandom_range(0, 1) == 1) new_req(prev_acked);
         end
         for (int i = 0; i < NC; i++) begin
            if (!s_req[i] && i != prev_acked) begin
               if ($urandom_range(0, 2) == 0) new_req(i);
               else begin
                  s_we[i]    = 1'($urandom_range(0, 1));
                  s_addr[i]  = $urandom;
                  s_wdata[i] = $urandom;
               end
            end
         end
         s_rst = ($urandom_range(0, 39) != 0);
         prev_acked = m_infl;
         cycle_begin();
         cycle_end();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shared data-memory arbiter between the N cores of the `cpu` top and its single-port data memory `dm`.
- Accepts one request per core, grants one access per cycle in round-robin order, and drives the memory port.
- Returns read data and a one-cycle ack to the winning core. This enables a fair multi-core programme, e.g. a 4-core string reversal, without port conflicts.

Parameters:
- CORES, 4, number of requesting cores (1..8)
- ADDR_W, 32, word-address width
- DATA_W, 32, data width
- IDX_W, $clog2(CORES) (min 1), width of the grant index

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- core_req  in  CORES  per-core access request, level, held until ack
- core_we  in  CORES  per-core write enable (1=store, 0=load)
- core_addr  in  CORES*ADDR_W  packed addresses, core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  CORES*DATA_W  packed store data
- core_ack  out  CORES  one-hot completion pulse
- core_rdata  out  DATA_W  load data, broadcast, valid with core_ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en

Behaviour:
- Interface: one clock, clk; reset is synchronous, active-low, port rst_n.
- Reset (rst_n=0 at posedge):
  - core_ack=0 and inflight_v=0; any pending access is dropped.
  - ptr=CORES-1, so core 0 has top priority on the first grant after reset.
  - mem_en=0 while rst_n=0.
- Issue stage (combinational, cycle N):
  - eligible = core_req & ~(inflight_v ? onehot(inflight_idx) : 0).
  - Winner = first eligible index scanning ptr+1, ptr+2, … modulo CORES.
  - If any eligible: mem_en=1, and mem_we/mem_addr/mem_wdata are taken from the winner.
  - Otherwise mem_en=0, mem_we=0, and addr/wdata are don't-care (driven 0).
- Registered at posedge ending cycle N:
  - inflight_v ← any eligible; inflight_idx ← winner.
  - ptr ← winner only if a grant occurred, else unchanged.
- Complete stage (cycle N+1):
  - core_ack[inflight_idx]=inflight_v (registered); core_rdata=mem_rdata (pass-through).
  - Store acks carry don't-care rdata.
- Latency and throughput:
  - Ack exactly 1 cycle after issue.
  - Throughput 1 access/cycle.
  - Each core has at most 1 outstanding access.
- Core contract:
  - Core samples ack at posedge and drops or changes req in the following cycle.
  - The in-flight mask prevents a double grant in the ack cycle.
  - A core re-asserting req right after ack is eligible in cycle N+2.
- Fairness: with all CORES requesting continuously, each core is granted exactly once every CORES cycles.
- CORES=1: pointer logic collapses; the lone core is granted every other cycle at most (mask rule).
- Ordering:
  - Same-address store then load from different cores resolves in grant order.
  - A store is committed at the posedge ending its issue cycle.
- Undefined core_addr on a non-requesting core is ignored.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- When defined, adds output port stat_grants (CORES*16), with per-core saturating 16-bit grant counters.
- Also adds output stat_stall (16), a saturating count of cycles where a requesting core was not granted (eligible-but-lost or masked).
- Both counters clear on reset.
- When undefined: ports and counters are absent, and core behaviour is identical.

Decomposition:
- Shared package dm_arb_pkg holds:
  - the default CORES/ADDR_W/DATA_W constants
  - a function rr_pick(req, ptr) returning {valid, idx}
  - the STAT_W=16 constant
- One natural sub-module: rr_arbiter (CORES-wide round-robin picker plus ptr register), reused by later instruction-fetch arbitration.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all core_req=1 -> core_ack=0000, mem_en=0; on the first cycle after release, core 0 wins and mem_addr=core 0's address.
- Single load: core 2 req, addr=5, memory[5]=32'd6 -> mem_en high in cycle N, core_ack=0100 in N+1, core_rdata=6; no other ack.
- Contention: all 4 cores hold req continuously -> ack order 0,1,2,3,0,1,…; each core is acked once per 4 cycles and never twice consecutively.
- Store/load ordering: core 1 stores 32'd8 to addr 0 while core 3 loads addr 0 -> core 1 wins first; core 3 rdata=8.
- Reset mid-operation: assert rst_n=0 in the ack cycle of an access -> core_ack=0 the next cycle and ptr restarts at core 0.
- With DM_ARB_STATS_EN: 8 cycles of all-4 contention -> each grant count=2; stat_stall=8.
